signed_product_bcd: RTL and testbench
=====================================

Name: signed_product_bcd

Overview:
- Downstream stage of the signed shift-add multiplier. Converts the two's-complement PRODUCT into a sign flag and sign-magnitude BCD digits for the HexBoard/seven-segment path.
- Sequential double-dabble: one add-3/shift step per clock, with a START/BUSY/DONE handshake.
- Holds the last result stable on its outputs while a new conversion runs.

Parameters:
W, 8, input product width in bits (two's complement)
DIGITS, 3, BCD output digits; must satisfy 10^DIGITS > 2^(W-1) (not checked in hardware)

Ports:
CLK  input  1  system clock, all state on rising edge
RESET  input  1  synchronous, active-high reset
START  input  1  request conversion; sampled only while BUSY=0
PRODUCT  input  W  signed two's-complement value, captured on the accepting edge
BUSY  output  1  conversion in progress
DONE  output  1  one-cycle pulse: BCD/NEG just updated
VALID  output  1  high once any conversion has completed since reset
NEG  output  1  sign of last converted value (1 = negative)
BCD  output  4*DIGITS  magnitude digits, digit 0 = BCD[3:0] = ones

Behaviour:
- One clock domain: CLK. RESET is synchronous and active-high.
- Reset, evaluated on the CLK edge with RESET=1:
  - state=IDLE; BUSY=0, DONE=0, VALID=0, NEG=0, BCD=0.
  - Internal shift register and counter cleared.
  - Reset overrides START.
  - Reset mid-conversion aborts the conversion; no DONE is issued.
- States: IDLE, SHIFT.
- IDLE:
  - If START=1 at edge k: capture PRODUCT.
    - Working NEG = PRODUCT[W-1].
    - Magnitude = PRODUCT[W-1] ? (~PRODUCT+1) : PRODUCT, treated as W-bit unsigned, so -2^(W-1) maps to 2^(W-1); e.g. 0x80 -> 128.
    - Load the magnitude into the binary part of the working register; clear the BCD scratch (4*DIGITS bits).
    - Set counter=W; go to SHIFT; BUSY=1 from edge k.
  - If START=0: remain in IDLE.
- SHIFT, one step per edge:
  - Every BCD scratch nibble >=5 gets +3.
  - Then the whole {scratch, binary} register shifts left 1.
  - Counter decrements.
- Final step (the edge where counter goes 1->0, i.e. edge k+W):
  - Copy scratch to BCD and working NEG to NEG.
  - DONE=1 for exactly one cycle; VALID=1; BUSY=0; state=IDLE.
- Latency: START accepted at edge k -> results and DONE at edge k+W (8 cycles for W=8).
- Back-to-back: a START high during the DONE cycle is accepted at the next edge, since BUSY=0. Sustained throughput is one conversion per W+1 cycles.
- START while BUSY=1 is ignored; it is not queued.
- PRODUCT changes while BUSY=1 have no effect.
- BCD/NEG are registered and change only on the DONE edge or reset; they never show intermediate scratch values.
- Zero and sign:
  - PRODUCT=0 gives NEG=0, BCD=0 (no negative zero).
  - NEG reflects the captured sign bit only.
- All BCD digits are always 0-9. Leading zeros are kept; blanking is the display's job.

Test Plan:
- RESET=1 for 2 cycles with START=1 -> BUSY=0, DONE=0, VALID=0, NEG=0, BCD=12'h000 throughout; no conversion begins.
- PRODUCT=8'h31 (49 = -7*-7), START pulse at edge k -> BUSY=1 for edges k..k+7, DONE=1 exactly at edge k+8, NEG=0, BCD=12'h049, VALID=1.
- Sign and range sweep, sequential conversions:
  - 8'hCF -> NEG=1, BCD=12'h049.
  - 8'h80 -> NEG=1, BCD=12'h128.
  - 8'h7F -> NEG=0, BCD=12'h127.
  - 8'h40 (64 = -8*-8) -> NEG=0, BCD=12'h064.
  - 8'h00 -> NEG=0, BCD=12'h000.
- Convert 8'h31, then START with PRODUCT=8'hFF at edge k+3 while BUSY -> ignored; result 049 at k+8. BCD holds the previous value (000) until k+8.
- Back-to-back: hold START=1 continuously, PRODUCT=8'hF9 (-7) then 8'h15 (21) -> DONE pulses 9 cycles apart; results NEG=1/007, then NEG=0/021.
- Reset mid-conversion: START with 8'h80, RESET at edge k+4 -> no DONE ever issued; outputs all zero, VALID=0. A new START with 8'h31 then completes normally with 049.

Source files
------------

// File: rtl/signed_product_bcd_if.sv
// Handshake and result bundle between a two's-complement product source and
// the BCD converter that drives the seven-segment path.
interface signed_product_bcd_if #(
    parameter int W      = 8,
    parameter int DIGITS = 3
);
    logic                  START;
    logic [W-1:0]          PRODUCT;
    logic                  BUSY;
    logic                  DONE;
    logic                  VALID;
    logic                  NEG;
    logic [4*DIGITS-1:0]   BCD;

    modport master (
        output START, PRODUCT,
        input  BUSY, DONE, VALID, NEG, BCD
    );

    modport slave (
        input  START, PRODUCT,
        output BUSY, DONE, VALID, NEG, BCD
    );
endinterface

// File: rtl/signed_product_bcd.sv
// Sequential double-dabble converter: signed product -> sign flag plus BCD
// magnitude, one add-3/shift step per clock, last result held on outputs.
module signed_product_bcd #(
    parameter int W      = 8,
    parameter int DIGITS = 3
) (
    input  logic                  CLK,
    input  logic                  RESET,
    signed_product_bcd_if.slave   bus
);
    localparam int SW = 4 * DIGITS;
    localparam int TW = SW + W;
    localparam int CW = $clog2(W + 1);

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t          r_state;
    state_t          w_state_next;
    logic [TW-1:0]   r_work;
    logic [TW-1:0]   w_adj;
    logic [TW-1:0]   w_shifted;
    logic [CW-1:0]   r_cnt;
    logic            r_neg_work;
    logic            r_neg;
    logic            r_done;
    logic            r_valid;
    logic [SW-1:0]   r_bcd;
    logic [W-1:0]    w_mag;
    logic            w_accept;
    logic            w_last;

    assign w_accept = (r_state == IDLE) && bus.START;
    assign w_last   = (r_state == SHIFT) && (r_cnt == CW'(1));

    // Plain W-bit negate, so the most negative value maps to 2^(W-1).
    assign w_mag = bus.PRODUCT[W-1] ? (~bus.PRODUCT + W'(1)) : bus.PRODUCT;

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_nibble
            assign w_adj[W+4*gi +: 4] = (r_work[W+4*gi +: 4] >= 4'd5)
                                      ? r_work[W+4*gi +: 4] + 4'd3
                                      : r_work[W+4*gi +: 4];
        end
    endgenerate

    assign w_adj[W-1:0] = r_work[W-1:0];
    assign w_shifted    = {w_adj[TW-2:0], 1'b0};

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (bus.START) w_state_next = SHIFT;
            SHIFT:   if (r_cnt == CW'(1)) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.BUSY  = (r_state == SHIFT);
        bus.DONE  = r_done;
        bus.VALID = r_valid;
        bus.NEG   = r_neg;
        bus.BCD   = r_bcd;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_work     <= '0;
            r_cnt      <= '0;
            r_neg_work <= 1'b0;
            r_neg      <= 1'b0;
            r_done     <= 1'b0;
            r_valid    <= 1'b0;
            r_bcd      <= '0;
        end else begin
            r_done <= 1'b0;
            if (w_accept) begin
                r_work     <= {{SW{1'b0}}, w_mag};
                r_cnt      <= CW'(W);
                r_neg_work <= bus.PRODUCT[W-1];
            end else if (r_state == SHIFT) begin
                r_work <= w_shifted;
                r_cnt  <= r_cnt - CW'(1);
                if (w_last) begin
                    r_bcd   <= w_shifted[TW-1:W];
                    r_neg   <= r_neg_work;
                    r_done  <= 1'b1;
                    r_valid <= 1'b1;
                end
            end
        end
    end
endmodule

// File: tb/tb_signed_product_bcd.sv
// Self-checking bench: vector table, corner sequences and random products
// compared against a decimal-arithmetic reference model.
module tb_signed_product_bcd;
    logic CLK;
    logic RESET;
    int   n_checks;
    int   n_fail;

    signed_product_bcd_if #(.W(8), .DIGITS(3)) bus ();

    signed_product_bcd #(.W(8), .DIGITS(3)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic [7:0]  product;
        logic        neg;
        logic [11:0] bcd;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    // Reference: signed decimal arithmetic, digits by division.
    function automatic void model(input logic [7:0] p, output logic neg, output logic [11:0] bcd);
        int v;
        int m;
        v   = int'($signed(p));
        neg = (v < 0);
        m   = neg ? -v : v;
        bcd = {4'(m / 100), 4'((m / 10) % 10), 4'(m % 10)};
    endfunction

    task automatic do_reset();
        @(negedge CLK);
        RESET     = 1'b1;
        bus.START = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    task automatic run_conv(input logic [7:0] p, input logic neg_req, input logic [11:0] bcd_req);
        int lat;
        lat = 0;
        @(negedge CLK);
        bus.START   = 1'b1;
        bus.PRODUCT = p;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        check("busy_after_accept", 32'(bus.BUSY), 32'd1);
        for (int i = 1; i <= 20; i++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                lat = i;
                break;
            end
        end
        check("latency", 32'(lat), 32'd8);
        check("neg", 32'(bus.NEG), 32'(neg_req));
        check("bcd", 32'(bus.BCD), 32'(bcd_req));
        check("valid", 32'(bus.VALID), 32'd1);
        check("busy_at_done", 32'(bus.BUSY), 32'd0);
        $display("conv %h -> neg=%0d bcd=%h latency=%0d", p, bus.NEG, bus.BCD, lat);
    endtask

    initial begin
        logic        mneg;
        logic [11:0] mbcd;
        int          d1;
        int          d2;
        logic [7:0]  rp;

        n_checks = 0;
        n_fail   = 0;
        vecs[0] = '{8'h31, 1'b0, 12'h049};
        vecs[1] = '{8'hCF, 1'b1, 12'h049};
        vecs[2] = '{8'h80, 1'b1, 12'h128};
        vecs[3] = '{8'h7F, 1'b0, 12'h127};
        vecs[4] = '{8'h40, 1'b0, 12'h064};
        vecs[5] = '{8'h00, 1'b0, 12'h000};

        // Reset held two cycles with START asserted
        RESET       = 1'b1;
        bus.START   = 1'b1;
        bus.PRODUCT = 8'h31;
        for (int i = 0; i < 2; i++) begin
            @(posedge CLK);
            #1;
            check("rst_busy", 32'(bus.BUSY), 32'd0);
            check("rst_done", 32'(bus.DONE), 32'd0);
            check("rst_valid", 32'(bus.VALID), 32'd0);
            check("rst_neg", 32'(bus.NEG), 32'd0);
            check("rst_bcd", 32'(bus.BCD), 32'd0);
        end
        @(negedge CLK);
        RESET     = 1'b0;
        bus.START = 1'b0;
        @(posedge CLK);
        #1;
        check("idle_after_rst", 32'(bus.BUSY), 32'd0);
        $display("reset sequence done");

        foreach (vecs[i]) run_conv(vecs[i].product, vecs[i].neg, vecs[i].bcd);

        // START while busy is ignored; outputs hold the previous result
        do_reset();
        @(negedge CLK);
        bus.START   = 1'b1;
        bus.PRODUCT = 8'h31;
        @(posedge CLK);
        #1;
        bus.START   = 1'b0;
        bus.PRODUCT = 8'hFF;
        for (int i = 1; i <= 7; i++) begin
            @(posedge CLK);
            #1;
            check("hold_bcd", 32'(bus.BCD), 32'h000);
            check("hold_busy", 32'(bus.BUSY), 32'd1);
            check("hold_done", 32'(bus.DONE), 32'd0);
            if (i == 2) bus.START = 1'b1;
            if (i == 3) bus.START = 1'b0;
        end
        @(posedge CLK);
        #1;
        check("ign_done", 32'(bus.DONE), 32'd1);
        check("ign_bcd", 32'(bus.BCD), 32'h049);
        check("ign_neg", 32'(bus.NEG), 32'd0);
        @(posedge CLK);
        #1;
        check("ign_not_queued", 32'(bus.BUSY), 32'd0);
        $display("ignored-start sequence: bcd=%h", bus.BCD);

        // Back-to-back with START held high
        d1 = 0;
        d2 = 0;
        @(negedge CLK);
        bus.START   = 1'b1;
        bus.PRODUCT = 8'hF9;
        @(posedge CLK);
        #1;
        bus.PRODUCT = 8'h15;
        for (int c = 1; c <= 30; c++) begin
            @(posedge CLK);
            #1;
            if (bus.DONE) begin
                if (d1 == 0) begin
                    d1 = c;
                    check("b2b_neg1", 32'(bus.NEG), 32'd1);
                    check("b2b_bcd1", 32'(bus.BCD), 32'h007);
                end else begin
                    d2 = c;
                    check("b2b_neg2", 32'(bus.NEG), 32'd0);
                    check("b2b_bcd2", 32'(bus.BCD), 32'h021);
                    bus.START = 1'b0;
                    break;
                end
            end
        end
        bus.START = 1'b0;
        check("b2b_first_lat", 32'(d1), 32'd8);
        check("b2b_spacing", 32'(d2 - d1), 32'd9);
        $display("back-to-back: done at %0d and %0d", d1, d2);

        // Reset mid-conversion aborts without DONE
        @(negedge CLK);
        bus.START   = 1'b1;
        bus.PRODUCT = 8'h80;
        @(posedge CLK);
        #1;
        bus.START = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            @(posedge CLK);
            #1;
        end
        RESET = 1'b1;
        @(posedge CLK);
        #1;
        RESET = 1'b0;
        for (int i = 0; i < 12; i++) begin
            @(posedge CLK);
            #1;
            check("abort_done", 32'(bus.DONE), 32'd0);
            check("abort_valid", 32'(bus.VALID), 32'd0);
            check("abort_bcd", 32'(bus.BCD), 32'd0);
            check("abort_neg", 32'(bus.NEG), 32'd0);
            check("abort_busy", 32'(bus.BUSY), 32'd0);
        end
        $display("abort sequence done");
        run_conv(8'h31, 1'b0, 12'h049);

        // Random products against the reference model
        for (int i = 0; i < 40; i++) begin
            rp = 8'($urandom_range(0, 255));
            model(rp, mneg, mbcd);
            run_conv(rp, mneg, mbcd);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
